pipe_hazard_scheduler: RTL and testbench
========================================

PIPE_HAZARD_SCHEDULER -- requirements
Module: pipe_hazard_scheduler

Interface
REQ-001 The block SHALL have these parameters: INIT_CYCLES, default 4, number of pipeline-purge cycles after reset (range 1..15); HOLD_TIMEOUT, default 64, number of consecutive hold cycles before timeout (range 2..255); CNT_WIDTH, default 16, width of the performance counters.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 id_rs, id_rt  input  5 each  source register fields of the instruction in ID.
REQ-005 id_uses_rt  input  1  high when the ID instruction reads rt (R-type, beq/bne, sw).
REQ-006 ex_memread, ex_rd  input  1, 5  load flag and destination register of the instruction in EX.
REQ-007 m_redirect  input  1  taken branch or jump resolved in the M stage; the target is valid on the PC mux.
REQ-008 ext_hold  input  1  external freeze request (e.g. a slow memory).
REQ-009 clear_cnt  input  1  synchronous clear of both counters.
REQ-010 pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en  output  1 each  load enables for the PC and the four pipeline registers.
REQ-011 if_id_flush, id_ex_flush, ex_m_flush, m_wb_flush  output  1 each  on the next edge the corresponding register loads all-zeros (NOP); flush overrides enable.
REQ-012 state  output  2  00 INIT, 01 RUN, 10 HOLD.
REQ-013 stall_cnt, flush_cnt  output  CNT_WIDTH each  count of load-use bubbles and count of redirects.
REQ-014 hold_timeout  output  1  sticky timeout flag.

Function
REQ-015 Enable and flush outputs SHALL be combinational from the state register and the current inputs, so they take effect on the same cycle as the event.
REQ-016 The block SHALL define hazard as ex_memread && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)).
REQ-017 INIT state SHALL behave as follows:
- all enables are 0 and all four flushes are 1;
- a 4-bit counter counts INIT_CYCLES cycles, then the block moves to RUN;
- the counters do not increment in INIT.
REQ-018 In RUN, the block SHALL evaluate these conditions each cycle, highest priority first:
- ext_hold: all enables 0, all flushes 0; next state HOLD.
- else m_redirect: all enables 1; if_id_flush, id_ex_flush and ex_m_flush are 1; flush_cnt increments.
- else hazard: pc_en 0, if_id_en 0, id_ex_flush 1, remaining enables 1; stall_cnt increments.
- else: all enables 1, all flushes 0.
REQ-019 In HOLD with ext_hold=1, the block SHALL hold all enables and all flushes at 0, and an 8-bit hold_len SHALL increment (saturating at 255).
REQ-020 In HOLD with ext_hold=0, the block SHALL drive outputs by the RUN rules of REQ-018 in that same cycle, set next state to RUN, and clear hold_len.
REQ-021 An m_redirect that arrives during HOLD SHALL NOT act until the hold is released; the frozen EX/M register keeps it asserted, and it is then applied once, on the release cycle.
REQ-022 hold_timeout SHALL set when hold_len reaches HOLD_TIMEOUT-1 while ext_hold=1, and SHALL clear only on reset.
REQ-023 Both counters SHALL saturate at all-ones; clear_cnt SHALL zero them and takes priority over an increment in the same cycle.
REQ-024 A hazard and m_redirect in the same cycle SHALL produce only the redirect action, and stall_cnt SHALL NOT increment.
REQ-025 State encoding 11 SHALL be unreachable; if it is entered, the next state SHALL be INIT.

Reset
REQ-026 While reset=0 the block SHALL drive:
- state = INIT, init counter 0, hold_len 0;
- stall_cnt = flush_cnt = 0, hold_timeout = 0;
- outputs as in INIT (enables 0, flushes 1).
REQ-027 Reset asserted mid-HOLD or mid-INIT SHALL abort the sequence immediately; after release, a full INIT_CYCLES purge SHALL follow.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Release reset with INIT_CYCLES=4 -> exactly 4 cycles of flushes 1 / enables 0, then state=01 and all enables 1.
- ex_memread=1, ex_rd=5, id_rs=5 for 1 cycle in RUN -> pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt=1; repeating with ex_rd=0 -> no stall.
- m_redirect=1 together with a hazard -> three flushes 1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- ext_hold=1 for 3 cycles while m_redirect=1 -> all outputs frozen for 3 cycles, then one redirect cycle with flush_cnt=1 (not 4).
- ext_hold=1 for 70 cycles with HOLD_TIMEOUT=64 -> hold_timeout rises after 64 held cycles and stays 1 after hold is released.
- Force stall_cnt to all-ones, then a hazard plus clear_cnt -> count holds at FFFF with the hazard alone; 0 with clear_cnt.

Source files
------------

// File: rtl/pipe_hazard_scheduler.sv
// ---------------------------------------------------------------------------
// pipe_hazard_scheduler
//
// Central stall/flush controller for a classic five-stage pipeline
// (IF, ID, EX, M, WB). It owns the load enables and NOP-flush controls of the
// PC and the four pipeline registers. It also runs a short purge sequence
// after reset, freezes the pipe on an external hold request, and keeps two
// performance counters.
//
// Parameters
//   INIT_CYCLES   purge cycles after reset (1..15)
//   HOLD_TIMEOUT  consecutive held cycles that raise hold_timeout (2..255)
//   CNT_WIDTH     width of the stall / flush performance counters
//
// Ports
//   clk                      sole clock, rising edge
//   reset                    asynchronous, active-low
//   id_rs, id_rt             source registers of the instruction in ID
//   id_uses_rt               ID instruction actually reads rt
//   ex_memread, ex_rd        EX instruction is a load / its destination
//   m_redirect               taken branch or jump resolved in M
//   ext_hold                 external freeze request
//   clear_cnt                synchronous clear of both performance counters
//   pc_en .. m_wb_en         load enables (PC, IF/ID, ID/EX, EX/M, M/WB)
//   if_id_flush..m_wb_flush  load NOP on the next edge; wins over the enable
//   state                    00 INIT, 01 RUN, 10 HOLD
//   stall_cnt, flush_cnt     load-use bubbles / redirects, saturating
//   hold_timeout             sticky: a hold lasted HOLD_TIMEOUT cycles
// ---------------------------------------------------------------------------
module pipe_hazard_scheduler #(
    parameter int unsigned INIT_CYCLES  = 4,
    parameter int unsigned HOLD_TIMEOUT = 64,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_uses_rt,
    input  logic                 ex_memread,
    input  logic [4:0]           ex_rd,
    input  logic                 m_redirect,
    input  logic                 ext_hold,
    input  logic                 clear_cnt,

    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_m_en,
    output logic                 m_wb_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_m_flush,
    output logic                 m_wb_flush,

    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt,
    output logic                 hold_timeout
);

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_BAD  = 2'b11
    } schedState_t;

    localparam logic [3:0] INIT_LAST    = 4'(INIT_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST    = 8'(HOLD_TIMEOUT - 1);
    localparam logic [7:0] HOLD_LEN_MAX = 8'hFF;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    schedState_t stateQ;
    schedState_t stateD;

    logic [3:0] initCnt;
    logic [7:0] holdLen;

    // Decoded per-cycle events, produced by the next-state process.
    logic holding;     // pipeline frozen by ext_hold this cycle
    logic stallEvent;  // load-use bubble inserted this cycle
    logic flushEvent;  // redirect applied this cycle

    // Load-use hazard: the ID instruction needs a value the EX load has not
    // produced yet. r0 is hard-wired to zero, so it never creates a hazard.
    logic hazard;
    assign hazard = ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    assign state = stateQ;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: every sequential block uses non-blocking assignments, so all
    // registers sample values from before the edge, whatever the block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= ST_INIT;
        end else begin
            stateQ <= stateD;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and pipeline controls
    //
    // RUN and HOLD share one rule set: a held pipe keeps everything frozen,
    // and the release cycle is an ordinary RUN cycle. An m_redirect that
    // arrives during a hold stays asserted from the frozen EX/M register, so
    // it is applied exactly once, on the release cycle.
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        stateD      = stateQ;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_m_en     = 1'b0;
        m_wb_en     = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_m_flush  = 1'b0;
        m_wb_flush  = 1'b0;
        holding     = 1'b0;
        stallEvent  = 1'b0;
        flushEvent  = 1'b0;

        case (stateQ)
            ST_INIT: begin
                // Purge: every pipeline register loads a NOP, nothing advances.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                ex_m_flush  = 1'b1;
                m_wb_flush  = 1'b1;
                if (initCnt == INIT_LAST) begin
                    stateD = ST_RUN;
                end
            end

            ST_RUN, ST_HOLD: begin
                if (ext_hold) begin
                    // Freeze: all enables and flushes stay low.
                    holding = 1'b1;
                    stateD  = ST_HOLD;
                end else begin
                    stateD   = ST_RUN;
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                    id_ex_en = 1'b1;
                    ex_m_en  = 1'b1;
                    m_wb_en  = 1'b1;
                    if (m_redirect) begin
                        // Squash the three younger instructions. The redirect
                        // also wins over a simultaneous load-use hazard,
                        // because the stalled instruction is squashed anyway.
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        ex_m_flush  = 1'b1;
                        flushEvent  = 1'b1;
                    end else if (hazard) begin
                        // Keep PC and IF/ID; put a bubble into ID/EX.
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        stallEvent  = 1'b1;
                    end
                end
            end

            default: begin
                // Illegal encoding: treat it like INIT and re-purge.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                ex_m_flush  = 1'b1;
                m_wb_flush  = 1'b1;
                stateD      = ST_INIT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Purge counter: runs only in INIT and rests at zero, so any later
    // re-entry into INIT (a reset, or the illegal state) gets a full purge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            initCnt <= 4'd0;
        end else if (stateQ == ST_INIT && initCnt != INIT_LAST) begin
            initCnt <= initCnt + 4'd1;
        end else begin
            initCnt <= 4'd0;
        end
    end

    // -----------------------------------------------------------------------
    // Hold length and sticky timeout.
    //
    // holdLen counts every frozen cycle, including the RUN cycle that starts
    // the hold. Its value is therefore the number of held cycles already
    // completed. The timeout sets on the edge that completes held cycle
    // HOLD_TIMEOUT. Only reset clears the timeout.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            holdLen      <= 8'd0;
            hold_timeout <= 1'b0;
        end else begin
            if (!holding) begin
                holdLen <= 8'd0;
            end else if (holdLen != HOLD_LEN_MAX) begin
                holdLen <= holdLen + 8'd1;
            end

            if (holding && holdLen == HOLD_LAST) begin
                hold_timeout <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Performance counters: saturating, and clear_cnt wins over an increment.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (clear_cnt) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallEvent && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flushEvent && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_scheduler
//
// Directed bench for pipe_hazard_scheduler with the default parameters
// (INIT_CYCLES=4, HOLD_TIMEOUT=64, CNT_WIDTH=16). Inputs change shortly after
// the falling edge. Combinational controls are sampled 1 time unit later.
// Registered results are sampled after the rising edge that follows.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rt, ex_memread, m_redirect, ext_hold, clear_cnt;
    logic        pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en;
    logic        if_id_flush, id_ex_flush, ex_m_flush, m_wb_flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;
    logic        hold_timeout;

    logic [4:0]  en;   // {pc, if_id, id_ex, ex_m, m_wb}
    logic [3:0]  fl;   // {if_id, id_ex, ex_m, m_wb}
    assign en = {pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en};
    assign fl = {if_id_flush, id_ex_flush, ex_m_flush, m_wb_flush};

    int checks   = 0;
    int failures = 0;

    pipe_hazard_scheduler #(
        .INIT_CYCLES (4),
        .HOLD_TIMEOUT(64),
        .CNT_WIDTH   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .m_redirect  (m_redirect),
        .ext_hold    (ext_hold),
        .clear_cnt   (clear_cnt),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .id_ex_en    (id_ex_en),
        .ex_m_en     (ex_m_en),
        .m_wb_en     (m_wb_en),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .ex_m_flush  (ex_m_flush),
        .m_wb_flush  (m_wb_flush),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .hold_timeout(hold_timeout)
    );

    always #5 clk = ~clk;

    // Safety net: the whole run is about 66k cycles (660k time units).
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge. Return 1 unit after the falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs      = 5'd0;
        id_rt      = 5'd0;
        id_uses_rt = 1'b0;
        ex_memread = 1'b0;
        ex_rd      = 5'd0;
        m_redirect = 1'b0;
        ext_hold   = 1'b0;
        clear_cnt  = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) cyc();
        check("rst_state", 32'(state), 32'h0);
        check("rst_en", 32'(en), 32'h00);
        check("rst_fl", 32'(fl), 32'hF);
        check("rst_stall", 32'(stall_cnt), 32'h0);
        check("rst_flush", 32'(flush_cnt), 32'h0);
        check("rst_tmo", 32'(hold_timeout), 32'h0);

        // ---------------- INIT purge: exactly 4 cycles ----------------
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("init%0d_state", i), 32'(state), 32'h0);
            check($sformatf("init%0d_en", i), 32'(en), 32'h00);
            check($sformatf("init%0d_fl", i), 32'(fl), 32'hF);
            cyc();
        end
        check("run_state", 32'(state), 32'h1);
        check("run_en", 32'(en), 32'h1F);
        check("run_fl", 32'(fl), 32'h0);
        check("init_no_count", 32'(stall_cnt), 32'h0);

        // ---------------- load-use hazard on rs ----------------
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        #1;
        check("haz_en", 32'(en), 32'h07);
        check("haz_fl", 32'(fl), 32'h4);
        cyc();
        idle_inputs();
        #1;
        check("haz_stall_cnt", 32'(stall_cnt), 32'h1);
        check("after_haz_en", 32'(en), 32'h1F);

        // ---------------- ex_rd = 0: never a hazard ----------------
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        #1;
        check("rd0_en", 32'(en), 32'h1F);
        check("rd0_fl", 32'(fl), 32'h0);
        cyc();
        check("rd0_stall_cnt", 32'(stall_cnt), 32'h1);

        // ---------------- rt match, rt not read: no stall ----------------
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
        id_uses_rt = 1'b0;
        #1;
        check("rt_unused_en", 32'(en), 32'h1F);
        // ---------------- rt match, rt read: stall ----------------
        id_uses_rt = 1'b1;
        #1;
        check("rt_used_en", 32'(en), 32'h07);
        check("rt_used_fl", 32'(fl), 32'h4);
        cyc();
        idle_inputs();
        #1;
        check("rt_stall_cnt", 32'(stall_cnt), 32'h2);

        // ---------------- redirect together with a hazard ----------------
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; m_redirect = 1'b1;
        #1;
        check("redir_haz_en", 32'(en), 32'h1F);
        check("redir_haz_fl", 32'(fl), 32'hE);
        cyc();
        idle_inputs();
        #1;
        check("redir_flush_cnt", 32'(flush_cnt), 32'h1);
        check("redir_stall_same", 32'(stall_cnt), 32'h2);

        // ---------------- clear_cnt ----------------
        clear_cnt = 1'b1;
        cyc();
        clear_cnt = 1'b0;
        check("clr_stall", 32'(stall_cnt), 32'h0);
        check("clr_flush", 32'(flush_cnt), 32'h0);

        // ---------------- hold for 3 cycles while m_redirect ----------------
        ext_hold = 1'b1; m_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("hold%0d_en", i), 32'(en), 32'h00);
            check($sformatf("hold%0d_fl", i), 32'(fl), 32'h0);
            cyc();
            check($sformatf("hold%0d_state", i), 32'(state), 32'h2);
            check($sformatf("hold%0d_flush_cnt", i), 32'(flush_cnt), 32'h0);
        end
        ext_hold = 1'b0;   // release; m_redirect still asserted
        #1;
        check("release_en", 32'(en), 32'h1F);
        check("release_fl", 32'(fl), 32'hE);
        cyc();
        m_redirect = 1'b0;
        #1;
        check("release_state", 32'(state), 32'h1);
        check("release_flush_cnt", 32'(flush_cnt), 32'h1);
        check("release_tmo", 32'(hold_timeout), 32'h0);

        // ---------------- 70-cycle hold: sticky timeout ----------------
        ext_hold = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            cyc();
            if (i == 62) check("tmo_early", 32'(hold_timeout), 32'h0);
            if (i == 66) check("tmo_set", 32'(hold_timeout), 32'h1);
        end
        check("long_hold_state", 32'(state), 32'h2);
        check("long_hold_en", 32'(en), 32'h00);
        ext_hold = 1'b0;
        cyc();
        check("tmo_release_state", 32'(state), 32'h1);
        repeat (3) cyc();
        check("tmo_sticky", 32'(hold_timeout), 32'h1);

        // ---------------- stall_cnt saturation and clear priority ----------------
        clear_cnt = 1'b1;
        cyc();
        clear_cnt = 1'b0;
        ex_memread = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
        repeat (65535) cyc();
        check("sat_reach", 32'(stall_cnt), 32'hFFFF);
        cyc();
        check("sat_hold", 32'(stall_cnt), 32'hFFFF);
        clear_cnt = 1'b1;
        cyc();
        clear_cnt = 1'b0;
        check("sat_clear", 32'(stall_cnt), 32'h0);
        idle_inputs();

        // ---------------- reset in the middle of a hold ----------------
        ext_hold = 1'b1;
        repeat (5) cyc();
        check("pre_rst_state", 32'(state), 32'h2);
        reset = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'h0);
        check("mid_rst_fl", 32'(fl), 32'hF);
        check("mid_rst_tmo", 32'(hold_timeout), 32'h0);
        ext_hold = 1'b0;
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("repurge%0d_state", i), 32'(state), 32'h0);
            cyc();
        end
        check("repurge_run", 32'(state), 32'h1);
        check("repurge_en", 32'(en), 32'h1F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
